// File: rtl/sdram_arbiter_if.sv
// Client-side request/response and core-side command/return bundle for sdram_arbiter.
// The slave modport is the arbiter; the master modport is the clients plus the SDRAM core.
interface sdram_arbiter_if #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_DEPTH = 25
);
  logic [NUM_PORTS-1:0]            req_rd;
  logic [NUM_PORTS-1:0]            req_wr;
  logic [NUM_PORTS*ADDR_DEPTH-1:0] req_addr;
  logic [NUM_PORTS*8-1:0]          req_wdata;
  logic [NUM_PORTS-1:0]            req_ack;
  logic [NUM_PORTS-1:0]            rsp_val;
  logic [7:0]                      rsp_data;
  logic                            core_rd;
  logic                            core_wr;
  logic [ADDR_DEPTH-1:0]           core_addr;
  logic [7:0]                      core_wdata;
  logic                            core_rdy;
  logic                            core_val;
  logic [7:0]                      core_data;

  modport master (
    output req_rd, req_wr, req_addr, req_wdata, core_rdy, core_val, core_data,
    input  req_ack, rsp_val, rsp_data, core_rd, core_wr, core_addr, core_wdata
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, core_rdy, core_val, core_data,
    output req_ack, rsp_val, rsp_data, core_rd, core_wr, core_addr, core_wdata
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM byte port; grant is combinational on core_rdy, read data returns 1 cycle after core_val.
// Reads stall (no ack) while the owner-tag FIFO is full; SDRAM_ARB_PRIO0_EN gives port 0 strict priority.
module sdram_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_DEPTH = 25,
  parameter int TAG_DEPTH  = 2,
  parameter int PID_W      = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_arbiter_if.slave       bus,
  output logic [TAG_DEPTH:0]   rd_outstanding,
  output logic                 err_orphan
);

  localparam int TW = $clog2(TAG_DEPTH);
  localparam logic [TAG_DEPTH:0] FULL_CNT = (TAG_DEPTH+1)'(TAG_DEPTH);

  logic [PID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PID_W-1:0]     tag_mem_q [TAG_DEPTH];
  logic [PID_W-1:0]     tag_mem_d [TAG_DEPTH];
  logic [TW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [TAG_DEPTH:0]   count_q, count_d;
  logic [NUM_PORTS-1:0] rsp_val_q, rsp_val_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 err_orphan_q, err_orphan_d;

  logic [NUM_PORTS-1:0] eligible;
  logic                 fifo_full, fifo_empty;
  logic                 grant, win_rd, push, pop;
  logic [PID_W-1:0]     win, idx;

  // Arbitration and command mux; everything is gated by rst_n so nothing leaks out during reset.
  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = (bus.req_rd[p] & ~fifo_full) | (bus.req_wr[p] & ~bus.req_rd[p]);
    end

    grant = 1'b0;
    win   = '0;
    idx   = '0;
    if (rst_n && bus.core_rdy) begin
`ifdef SDRAM_ARB_PRIO0_EN
      if (eligible[0]) begin
        grant = 1'b1;
      end
`endif
      for (int k = 1; k <= NUM_PORTS; k++) begin
        idx = PID_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
        if (!grant && eligible[idx]) begin
          grant = 1'b1;
          win   = idx;
        end
      end
    end

    win_rd         = 1'b0;
    bus.req_ack    = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant && (win == PID_W'(p))) begin
        win_rd         = bus.req_rd[p];
        bus.req_ack[p] = 1'b1;
        bus.core_addr  = bus.req_addr[p*ADDR_DEPTH +: ADDR_DEPTH];
        bus.core_wdata = bus.req_wdata[p*8 +: 8];
      end
    end
    bus.core_rd = grant & win_rd;
    bus.core_wr = grant & ~win_rd;
  end

  always_comb begin
    push = grant & win_rd;
    pop  = bus.core_val & ~fifo_empty;

    rr_ptr_d = rr_ptr_q;
`ifdef SDRAM_ARB_PRIO0_EN
    if (grant && (win != '0)) begin
      rr_ptr_d = win;
    end
`else
    if (grant) begin
      rr_ptr_d = win;
    end
`endif

    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = win;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Return routing uses the head tag as it stood before this cycle's push.
    rsp_val_d  = '0;
    rsp_data_d = '0;
    if (pop) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (tag_mem_q[rd_ptr_q] == PID_W'(p)) begin
          rsp_val_d[p] = 1'b1;
        end
      end
      rsp_data_d = bus.core_data;
    end

    err_orphan_d = err_orphan_q | (bus.core_val & fifo_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= PID_W'(NUM_PORTS - 1);
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_val_q    <= '0;
      rsp_data_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      tag_mem_q    <= tag_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_val_q    <= rsp_val_d;
      rsp_data_q   <= rsp_data_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign bus.rsp_val    = rsp_val_q;
  assign bus.rsp_data   = rsp_data_q;
  assign rd_outstanding = count_q;
  assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized bench for sdram_arbiter against a queue-based reference model.
module tb_sdram_arbiter;
  localparam int N  = 3;
  localparam int AD = 25;
  localparam int TD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.NUM_PORTS(N), .ADDR_DEPTH(AD)) bus ();
  logic [TD:0] rd_outstanding;
  logic        err_orphan;

  sdram_arbiter #(.NUM_PORTS(N), .ADDR_DEPTH(AD), .TAG_DEPTH(TD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .rd_outstanding (rd_outstanding),
    .err_orphan     (err_orphan)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus state: what each client and the core model present this cycle.
  bit          t_rd [N];
  bit          t_wr [N];
  logic [AD-1:0] t_addr [N];
  logic [7:0]  t_wdata [N];
  bit          t_rdy, t_val, core_auto;
  logic [7:0]  t_data;

  // Reference model: rotation pointer, ordered owner list, pending response.
  int          m_rr;
  int          m_tags[$];
  logic [N-1:0] m_rsp_val;
  logic [7:0]  m_rsp_data;
  bit          m_orphan;
  logic [7:0]  core_q[$];

  logic [N-1:0]  last_ack, last_rsp_val;
  logic [7:0]    last_rsp_data, last_wdata;
  logic [AD-1:0] last_addr;
  logic          last_rd, last_wr, last_err;
  logic [TD:0]   last_rdo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = N - 1;
    m_tags.delete();
    core_q.delete();
    m_rsp_val  = '0;
    m_rsp_data = '0;
    m_orphan   = 1'b0;
  endtask

  function automatic int model_winner();
    bit elig [N];
    int p;
    for (int i = 0; i < N; i++)
      elig[i] = (t_rd[i] && m_tags.size() < TD) || (t_wr[i] && !t_rd[i]);
    if (!t_rdy) return -1;
`ifdef SDRAM_ARB_PRIO0_EN
    if (elig[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      p = (m_rr + k) % N;
      if (elig[p]) return p;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_rd[i]             = t_rd[i];
      bus.req_wr[i]             = t_wr[i];
      bus.req_addr[i*AD +: AD]  = t_addr[i];
      bus.req_wdata[i*8 +: 8]   = t_wdata[i];
    end
    bus.core_rdy  = t_rdy;
    bus.core_val  = t_val;
    bus.core_data = t_data;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      t_rd[i] = 0; t_wr[i] = 0; t_addr[i] = '0; t_wdata[i] = '0;
    end
    t_rdy = 0; t_val = 0; t_data = '0;
  endtask

  // One clock: drive at negedge, check registered and combinational outputs, advance the model.
  task automatic tick();
    int win;
    int p;
    logic [31:0] e_ack, e_rd, e_wr, e_addr, e_wdata;
    @(negedge clk);
    if (core_auto) begin
      t_val  = (core_q.size() > 0) && ($urandom_range(0, 2) == 0);
      t_data = t_val ? core_q[0] : 8'h00;
    end
    drive();
    #1;
    last_ack = bus.req_ack;   last_rsp_val = bus.rsp_val; last_rsp_data = bus.rsp_data;
    last_rd = bus.core_rd;    last_wr = bus.core_wr;      last_addr = bus.core_addr;
    last_wdata = bus.core_wdata; last_err = err_orphan;   last_rdo = rd_outstanding;

    chk("rsp_val", last_rsp_val, m_rsp_val);
    chk("rsp_data", last_rsp_data, m_rsp_data);
    chk("rd_outstanding", last_rdo, m_tags.size());
    chk("err_orphan", last_err, m_orphan);

    win = model_winner();
    e_ack = 0; e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0;
    if (win >= 0) begin
      e_ack   = 1 << win;
      e_rd    = t_rd[win] ? 1 : 0;
      e_wr    = t_rd[win] ? 0 : 1;
      e_addr  = 32'(t_addr[win]);
      e_wdata = 32'(t_wdata[win]);
    end
    chk("req_ack", last_ack, e_ack);
    chk("core_rd", last_rd, e_rd);
    chk("core_wr", last_wr, e_wr);
    chk("core_addr", last_addr, e_addr);
    chk("core_wdata", last_wdata, e_wdata);

    m_rsp_val  = '0;
    m_rsp_data = '0;
    if (t_val) begin
      if (m_tags.size() > 0) begin
        p = m_tags.pop_front();
        m_rsp_val  = N'(1 << p);
        m_rsp_data = t_data;
      end else begin
        m_orphan = 1'b1;
      end
      if (core_auto) void'(core_q.pop_front());
    end
    if (win >= 0) begin
`ifdef SDRAM_ARB_PRIO0_EN
      if (win != 0) m_rr = win;
`else
      m_rr = win;
`endif
      if (t_rd[win]) begin
        m_tags.push_back(win);
        if (core_auto) core_q.push_back(8'($urandom));
      end
      t_rd[win] = 0;
      t_wr[win] = 0;
    end
    t_val = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_stim();
    for (int i = 0; i < N; i++) t_rd[i] = 1;
    t_rdy = 1;
    drive();
    #1;
    chk("rst_req_ack", bus.req_ack, 0);
    chk("rst_core_rd", bus.core_rd, 0);
    chk("rst_core_wr", bus.core_wr, 0);
    chk("rst_rsp_val", bus.rsp_val, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rd_outstanding", rd_outstanding, 0);
    chk("rst_err_orphan", err_orphan, 0);
    @(negedge clk);
    clear_stim();
    drive();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    core_auto = 0;
    clear_stim();
    drive();
    do_reset();

    // Three readers, core always ready: rotation 0,1,2,0 with returns draining the tag FIFO.
    t_rdy = 1;
    t_rd[0] = 1; t_addr[0] = 25'h000010;
    t_rd[1] = 1; t_addr[1] = 25'h000020;
    t_rd[2] = 1; t_addr[2] = 25'h000030;
    tick();
    chk("rr_ack0", last_ack, 3'b001);   chk("rr_addr0", last_addr, 25'h000010);
    t_val = 1; t_data = 8'h31;
    tick();
    chk("rr_ack1", last_ack, 3'b010);   chk("rr_addr1", last_addr, 25'h000020);
    t_rd[0] = 1; t_addr[0] = 25'h000010;
    t_val = 1; t_data = 8'h32;
    tick();
    chk("rr_ack2", last_ack, 3'b100);   chk("rr_addr2", last_addr, 25'h000030);
    t_val = 1; t_data = 8'h33;
    tick();
    chk("rr_ack3", last_ack, 3'b001);   chk("rr_addr3", last_addr, 25'h000010);
    t_val = 1; t_data = 8'h34;
    tick();
    tick();

    // Write held off by core_rdy low.
    t_wr[1] = 1; t_addr[1] = 25'h1ABCDE; t_wdata[1] = 8'h55; t_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_no_ack", last_ack, 0);
    end
    t_rdy = 1;
    tick();
    chk("wr_ack", last_ack, 3'b010);
    chk("wr_core_wr", last_wr, 1);
    chk("wr_wdata", last_wdata, 8'h55);
    chk("wr_addr", last_addr, 25'h1ABCDE);

    // Single read from port 2, core returns four cycles after the grant.
    t_rd[2] = 1; t_addr[2] = 25'h000040;
    tick();
    chk("rd2_ack", last_ack, 3'b100);
    tick();
    chk("rd2_outstanding1", last_rdo, 1);
    tick();
    tick();
    t_val = 1; t_data = 8'hA7;
    tick();
    tick();
    chk("rd2_rsp_val", last_rsp_val, 3'b100);
    chk("rd2_rsp_data", last_rsp_data, 8'hA7);
    chk("rd2_outstanding0", last_rdo, 0);

    // Full tag FIFO blocks a read but lets a write through; returns routed in issue order.
    t_rd[0] = 1; t_addr[0] = 25'h000050;
    t_rd[1] = 1; t_addr[1] = 25'h000060;
    tick();
    tick();
    t_rd[2] = 1; t_addr[2] = 25'h000070;
    t_wr[0] = 1; t_addr[0] = 25'h000080; t_wdata[0] = 8'h9C;
    tick();
    chk("full_rdo", last_rdo, 2);
    chk("full_wr_pass_ack", last_ack, 3'b001);
    chk("full_wr_pass_wr", last_wr, 1);
    tick();
    chk("full_rd_blocked", last_ack, 0);
    t_val = 1; t_data = 8'h11;
    tick();
    chk("full_still_blocked", last_ack, 0);
    t_val = 1; t_data = 8'h22;
    tick();
    chk("ret0_rsp_val", last_rsp_val, 3'b001);
    chk("ret0_rsp_data", last_rsp_data, 8'h11);
    chk("unblock_ack2", last_ack, 3'b100);
    tick();
    chk("ret1_rsp_val", last_rsp_val, 3'b010);
    chk("ret1_rsp_data", last_rsp_data, 8'h22);
    chk("pushpop_rdo", last_rdo, 1);
    t_val = 1; t_data = 8'h33;
    tick();
    tick();
    chk("ret2_rsp_val", last_rsp_val, 3'b100);

    // Orphan return with an empty FIFO.
    t_val = 1; t_data = 8'hEE;
    tick();
    tick();
    chk("orphan_no_rsp", last_rsp_val, 0);
    chk("orphan_flag", last_err, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("orphan_sticky", last_err, 1);
    do_reset();

`ifdef SDRAM_ARB_PRIO0_EN
    t_rdy = 1;
    t_addr[0] = 25'h000100; t_wdata[0] = 8'h01;
    t_addr[1] = 25'h000200; t_wdata[1] = 8'h02;
    for (int i = 0; i < 6; i++) begin
      t_wr[0] = 1; t_wr[1] = 1;
      tick();
      chk("prio_port0", last_ack, 3'b001);
    end
    tick();
    chk("prio_port1_next", last_ack, 3'b010);
    tick();
`endif

    // Randomized traffic with an in-order core model returning reads after random delays.
    core_auto = 1;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!t_rd[p] && !t_wr[p] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0:       t_rd[p] = 1;
            1:       t_wr[p] = 1;
            default: begin t_rd[p] = 1; t_wr[p] = 1; end
          endcase
          t_addr[p]  = AD'($urandom);
          t_wdata[p] = 8'($urandom);
        end
      end
      t_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    clear_stim();
    for (int c = 0; c < 300 && m_tags.size() > 0; c++) tick();
    tick();
    chk("drain_rd_outstanding", last_rdo, 0);
    chk("drain_no_orphan", last_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
